// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller
// for the MEM stage. Loads and stores hit in zero extra cycles; a miss raises
// the global stall, writes back a dirty victim line if needed, refills the line
// from the slow handshake memory and then lets the still-stalled access retry.
// Optional build macro DCACHE_STATS_EN adds hit/miss counters (hit_cnt_o,
// miss_cnt_o); without it those ports and counters do not exist.
module dcache_ctrl #(
    parameter int IDX_W  = 5,
    parameter int LINE_W = 256,
    parameter int TAG_W  = 27 - IDX_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int LINES = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    state_t            state_q;
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  cpu_tag;
    logic [2:0]        wsel;
    logic              idle;
    logic              hit;
    logic              miss;
    logic              addr_unused;

    // Address split and the combinational hit/miss decision.
    assign idx         = cpu_addr_i[5 +: IDX_W];
    assign cpu_tag     = cpu_addr_i[31 -: TAG_W];
    assign wsel        = cpu_addr_i[4:2];
    assign addr_unused = ^cpu_addr_i[1:0];
    assign idle        = (state_q == IDLE);
    assign hit         = cpu_req_i & valid_q[idx] & (tag_q[idx] == cpu_tag);
    assign miss        = idle & cpu_req_i & ~hit;

    // A miss stalls in the very cycle it is seen; reset forces the stall low.
    assign stall_o     = rst_i & (~idle | miss);
    assign cpu_rdata_o = (idle & hit & ~cpu_we_i) ? data_q[idx][{wsel, 5'b0} +: 32] : 32'd0;

    // Control FSM: line state bits and registered memory-side outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req_i) begin
                        if (hit) begin
                            if (cpu_we_i) begin
                                dirty_q[idx] <= 1'b1;
                            end
                        end else if (valid_q[idx] && dirty_q[idx]) begin
                            state_q     <= WRITEBACK;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= 1'b1;
                            mem_addr_o  <= {tag_q[idx], idx, 5'b0};
                            mem_wdata_o <= data_q[idx];
                        end else begin
                            state_q     <= ALLOCATE;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= 1'b0;
                            mem_addr_o  <= {cpu_tag, idx, 5'b0};
                            mem_wdata_o <= '0;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state_q     <= ALLOCATE;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= {cpu_tag, idx, 5'b0};
                        mem_wdata_o <= '0;
                    end
                end
                ALLOCATE: begin
                    if (mem_ack_i) begin
                        state_q      <= IDLE;
                        mem_req_o    <= 1'b0;
                        mem_addr_o   <= '0;
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    mem_req_o   <= 1'b0;
                    mem_we_o    <= 1'b0;
                    mem_addr_o  <= '0;
                    mem_wdata_o <= '0;
                end
            endcase
        end
    end

    // Tag and data arrays: store-hit word merge and refill line write, never reset.
    always_ff @(posedge clk_i) begin
        if (idle && hit && cpu_we_i) begin
            data_q[idx][{wsel, 5'b0} +: 32] <= cpu_wdata_i;
        end else if (state_q == ALLOCATE && mem_ack_i) begin
            data_q[idx] <= mem_rdata_i;
            tag_q[idx]  <= cpu_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    logic retry_q;

    // Hit/miss counters; the retry flag keeps the post-refill hit from counting.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            retry_q    <= 1'b0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (idle) begin
                retry_q <= 1'b0;
                if (hit && !retry_q) begin
                    hit_cnt_o <= hit_cnt_o + 32'd1;
                end
                if (miss) begin
                    miss_cnt_o <= miss_cnt_o + 32'd1;
                end
            end else if (state_q == ALLOCATE && mem_ack_i) begin
                retry_q <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed and randomized bench for dcache_ctrl. A line-level
// cache model plus a backing-store memory model predict every cycle's outputs;
// the bench also plays the slow memory with random ack latency.
module tb_dcache_ctrl;

    logic         clk_i;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_wdata_i;
    logic [31:0]  cpu_rdata_o;
    logic         stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic [255:0] mem_rdata_i;
    logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;
`endif

    dcache_ctrl dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o   (hit_cnt_o),
        .miss_cnt_o  (miss_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Per-cycle expectations set by the stimulus side, checked at negedge.
    bit           chk_en    = 0;
    bit           exp_stall = 0;
    bit           exp_req   = 0;
    bit           exp_we    = 0;
    logic [31:0]  exp_addr  = '0;
    logic [255:0] exp_wdata = '0;
    bit           chk_wdata = 0;
    bit           chk_rdata = 0;
    logic [31:0]  exp_rdata = '0;

    // Observation helpers used by the literal checks.
    int           stall_cycles = 0;
    int           wb_count     = 0;
    logic [31:0]  last_wb_addr = '0;
    logic [255:0] last_wb_data = '0;
    logic [31:0]  got_rdata    = '0;
    int           force_lat    = -1;

    // Behavioural model: cache lines and backing memory keyed by line number.
    bit           mvalid [32];
    bit           mdirty [32];
    logic [21:0]  mtag   [32];
    logic [255:0] mdata  [32];
    logic [255:0] mmem   [int unsigned];
    int           mhit   = 0;
    int           mmiss  = 0;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] randLine();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Single compare process: DUT outputs against the model every cycle.
    always @(negedge clk_i) begin
        if (stall_o === 1'b1) stall_cycles++;
        if (mem_req_o === 1'b1 && mem_we_o === 1'b1) begin
            last_wb_addr = mem_addr_o;
            last_wb_data = mem_wdata_o;
            if (mem_ack_i === 1'b1) wb_count++;
        end
        if (chk_en) begin
            checkOutput("stall", stall_o, exp_stall);
            checkOutput("mem_req", mem_req_o, exp_req);
            if (exp_req) begin
                checkOutput("mem_we", mem_we_o, exp_we);
                checkOutput("mem_addr", mem_addr_o, exp_addr);
            end
            if (chk_wdata) checkOutput("mem_wdata", mem_wdata_o, exp_wdata);
            if (chk_rdata) checkOutput("cpu_rdata", cpu_rdata_o, exp_rdata);
        end
    end

    task automatic modelReset();
        for (int i = 0; i < 32; i++) begin
            mvalid[i] = 0;
            mdirty[i] = 0;
        end
        mhit  = 0;
        mmiss = 0;
    endtask

    task automatic memTransaction(input bit is_wb, input logic [31:0] addr, input logic [255:0] line);
        int lat;
        lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
        for (int c = 0; c <= lat; c++) begin
            exp_stall   = 1;
            exp_req     = 1;
            exp_we      = is_wb;
            exp_addr    = addr;
            exp_wdata   = line;
            chk_wdata   = is_wb;
            chk_rdata   = 0;
            mem_ack_i   = (c == lat);
            mem_rdata_i = (!is_wb && c == lat) ? line : randLine();
            @(posedge clk_i); #1;
        end
        mem_ack_i   = 0;
        mem_rdata_i = randLine();
    endtask

    task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [31:0] wd);
        logic [4:0]  idx;
        logic [21:0] tag;
        logic [2:0]  w;
        logic [31:0] la;
        logic [31:0] victim;
        idx = addr[9:5];
        tag = addr[31:10];
        w   = addr[4:2];
        la  = {addr[31:5], 5'b0};
        chk_en      = 1;
        cpu_req_i   = 1;
        cpu_we_i    = we;
        cpu_addr_i  = addr;
        cpu_wdata_i = wd;
        if (!(mvalid[idx] && mtag[idx] == tag)) begin
            mmiss++;
            exp_stall = 1;
            exp_req   = 0;
            chk_wdata = 0;
            chk_rdata = 0;
            @(posedge clk_i); #1;
            if (mvalid[idx] && mdirty[idx]) begin
                victim = {mtag[idx], idx, 5'b0};
                memTransaction(1, victim, mdata[idx]);
                mmem[victim >> 5] = mdata[idx];
            end
            if (!mmem.exists(la >> 5)) mmem[la >> 5] = randLine();
            memTransaction(0, la, mmem[la >> 5]);
            mvalid[idx] = 1;
            mdirty[idx] = 0;
            mtag[idx]   = tag;
            mdata[idx]  = mmem[la >> 5];
        end else begin
            mhit++;
        end
        exp_stall = 0;
        exp_req   = 0;
        chk_wdata = 0;
        chk_rdata = !we;
        exp_rdata = mdata[idx][int'(w)*32 +: 32];
        @(negedge clk_i); #1;
        got_rdata = cpu_rdata_o;
        @(posedge clk_i); #1;
        if (we) begin
            mdata[idx][int'(w)*32 +: 32] = wd;
            mdirty[idx] = 1;
        end
        cpu_req_i = 0;
        chk_rdata = 0;
    endtask

    task automatic idleCycles(input int n);
        for (int c = 0; c < n; c++) begin
            cpu_req_i   = 0;
            cpu_we_i    = $urandom_range(0, 1);
            cpu_addr_i  = $urandom;
            exp_stall   = 0;
            exp_req     = 0;
            chk_wdata   = 0;
            chk_rdata   = 0;
            mem_ack_i   = ($urandom_range(0, 3) == 0);
            mem_rdata_i = randLine();
            @(posedge clk_i); #1;
        end
        mem_ack_i = 0;
    endtask

    initial begin
        logic [255:0] tmp;
        int s0;
        int wb0;
        rst_i       = 0;
        cpu_req_i   = 1;
        cpu_we_i    = 0;
        cpu_addr_i  = 32'h40;
        cpu_wdata_i = 0;
        mem_ack_i   = 0;
        mem_rdata_i = '0;
        modelReset();

        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("rst_stall_with_req", stall_o, 1'b0);
        checkOutput("rst_rdata", cpu_rdata_o, 32'd0);
        cpu_req_i = 0;
        rst_i     = 1;
        @(negedge clk_i); #1;
        checkOutput("post_rst_stall", stall_o, 1'b0);
        checkOutput("post_rst_req", mem_req_o, 1'b0);
        @(posedge clk_i); #1;

        // Cold miss on 0x40 with a fixed three-cycle refill wait.
        tmp = randLine();
        tmp[95:64] = 32'hDEADBEEF;
        mmem[32'h40 >> 5] = tmp;
        force_lat = 3;
        s0 = stall_cycles;
        applyStimulus(0, 32'h40, 0);
        checkOutput("cold_miss_stall_cycles", stall_cycles - s0, 5);
        applyStimulus(0, 32'h48, 0);
        checkOutput("load_48", got_rdata, 32'hDEADBEEF);

        // Store hit then immediate reload.
        s0 = stall_cycles;
        applyStimulus(1, 32'h44, 32'h12345678);
        applyStimulus(0, 32'h44, 0);
        checkOutput("store_hit_no_stall", stall_cycles - s0, 0);
        checkOutput("load_44", got_rdata, 32'h12345678);

        // Dirty conflict miss: write-back of line 0x40 first.
        force_lat = 1;
        wb0 = wb_count;
        applyStimulus(0, 32'h440, 0);
        checkOutput("dirty_wb_count", wb_count - wb0, 1);
        checkOutput("dirty_wb_addr", last_wb_addr, 32'h40);
        checkOutput("dirty_wb_word1", last_wb_data[63:32], 32'h12345678);
        checkOutput("dirty_wb_word2", last_wb_data[95:64], 32'hDEADBEEF);

        // Clean conflict miss: no write-back, data comes from memory.
        wb0 = wb_count;
        applyStimulus(0, 32'h44, 0);
        checkOutput("clean_wb_count", wb_count - wb0, 0);
        checkOutput("clean_reload_44", got_rdata, 32'h12345678);

        // Reset in the middle of a refill, then a stray ack.
        chk_en     = 0;
        cpu_req_i  = 1;
        cpu_we_i   = 0;
        cpu_addr_i = 32'h840;
        @(posedge clk_i); #1;
        checkOutput("alloc_req", mem_req_o, 1'b1);
        checkOutput("alloc_addr", mem_addr_o, 32'h840);
        @(posedge clk_i); #1;
        rst_i = 0;
        #1;
        checkOutput("midmiss_rst_req", mem_req_o, 1'b0);
        checkOutput("midmiss_rst_stall", stall_o, 1'b0);
        modelReset();
        repeat (2) @(posedge clk_i);
        #1;
        cpu_req_i   = 0;
        rst_i       = 1;
        mem_ack_i   = 1;
        mem_rdata_i = randLine();
        @(posedge clk_i); #1;
        mem_ack_i = 0;
        checkOutput("stray_ack_req", mem_req_o, 1'b0);
        checkOutput("stray_ack_stall", stall_o, 1'b0);
        force_lat = 0;
        s0 = stall_cycles;
        applyStimulus(0, 32'h44, 0);
        checkOutput("after_rst_miss_stall", stall_cycles - s0, 2);
        checkOutput("after_rst_reload_44", got_rdata, 32'h12345678);

        // Randomized traffic over a few tags and indexes.
        force_lat = -1;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = {20'd0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            applyStimulus($urandom_range(0, 9) < 4, a, $urandom);
            if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 2));
        end
        idleCycles(1);

`ifdef DCACHE_STATS_EN
        checkOutput("hit_cnt", hit_cnt_o, mhit);
        checkOutput("miss_cnt", miss_cnt_o, mmiss);
`endif

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data-cache controller in the MEM stage of the 5-stage pipeline.
- Serves the stage's load/store port from internal tag/data arrays.
- Sequences line write-back and refill against a slow handshake memory.
- Drives the global memStall that freezes every pipe register, MEM_WB included, while a miss is serviced.

Parameters:
- IDX_W, 5, index bits; cache holds 2**IDX_W lines.
- LINE_W, 256, line width in bits (32 bytes, 8 words); fixed offset field = addr[4:0].
- TAG_W, 27-IDX_W, tag bits; tag = addr[31:5+IDX_W].

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- cpu_req_i  in  1  MEM stage access valid (MemRead | MemWrite)
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address; bits [1:0] ignored (word accesses only)
- cpu_wdata_i  in  32  store data
- cpu_rdata_o  out  32  load data, valid in the cycle stall_o=0
- stall_o  out  1  memStall to all pipe registers and PC
- mem_req_o  out  1  memory transaction request
- mem_we_o  out  1  1 = line write-back, 0 = line refill
- mem_addr_o  out  32  line-aligned address, bits [4:0]=0
- mem_wdata_o  out  LINE_W  victim line
- mem_rdata_i  in  LINE_W  refill line, valid with mem_ack_i
- mem_ack_i  in  1  one-cycle pulse completing the current transaction

Behaviour:
- Storage: per line valid, dirty, tag, LINE_W data; word select = addr[4:2].
- hit = cpu_req_i & valid[idx] & (tag[idx]==addr tag), computed combinationally.
- Reset (any time, including mid-miss):
  - state=IDLE; all valid/dirty cleared; mem_req_o=0, mem_we_o=0.
  - stall_o=0, cpu_rdata_o=0.
  - Data array is not cleared.
  - An in-flight memory transaction is abandoned; a late ack in IDLE is ignored.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - cpu_req_i=0: stall_o=0, no state change.
  - Load hit: cpu_rdata_o = selected word, same cycle; stall_o=0. Zero extra latency.
  - Store hit: at posedge, word written and dirty=1; stall_o=0.
  - Miss: stall_o=1 combinationally in the same cycle. Next state WRITEBACK if valid & dirty, else ALLOCATE.
- WRITEBACK:
  - Outputs: mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag, idx, 5'b0}, mem_wdata_o = victim line; stall_o=1.
  - Outputs held stable until mem_ack_i.
  - On ack: go to ALLOCATE. The next cycle starts a new transaction even though mem_req_o stays 1.
- ALLOCATE:
  - Outputs: mem_req_o=1, mem_we_o=0, mem_addr_o={cpu tag, idx, 5'b0}; stall_o=1.
  - On ack: line = mem_rdata_i, tag updated, valid=1, dirty=0; go to IDLE.
- Retry after miss: the still-stalled request re-evaluates in IDLE and hits. It completes there with stall_o=0 (store merges and sets dirty).
- Miss penalty = wb latency + refill latency + 1 cycle. Minimum 2 cycles if ack arrives in the first cycle of each state.
- cpu_* inputs must stay stable while stall_o=1. The stall freezes the EX_MEM pipe register, so this holds by construction.
- mem_rdata_i is ignored outside ALLOCATE; mem_ack_i is ignored in IDLE.
- Outside WRITEBACK/ALLOCATE: mem_req_o=0; mem_addr_o and mem_wdata_o are don't-care (drive 0).

Optional Feature:
- DCACHE_STATS_EN defined:
  - Adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0], reset to 0, wrapping at 2**32.
  - Miss counted once, on the IDLE→WRITEBACK/ALLOCATE transition.
  - Hit counted on completion of an IDLE hit, except the retry that completes a miss. A registered "retry" flag, set on leaving ALLOCATE and cleared in IDLE, suppresses that count.
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then load 0x0000_0040 → stall_o=1 same cycle, ALLOCATE with mem_addr_o=0x40, mem_we_o=0. Ack after 3 cycles with line word2=0xDEADBEEF; load 0x48 → rdata 0xDEADBEEF. Total stall 5 cycles.
- Store 0x1234_5678 to 0x44 after that refill → no stall; immediate load 0x44 returns 0x12345678; dirty=1.
- Load 0x0000_0440 (same idx 2, different tag) with dirty victim → WRITEBACK first: addr 0x40, mem_wdata_o word1=0x12345678. Then ALLOCATE at addr 0x440; then hit.
- Clean conflict miss (reload 0x40 after the previous case) → goes directly to ALLOCATE; no write-back transaction.
- Assert rst_i low during ALLOCATE → mem_req_o=0, stall_o=0 immediately. Previous hit address now misses. A stray ack after reset does not change state.
- DCACHE_STATS_EN: sequence hit, miss+retry, hit → hit_cnt_o=2, miss_cnt_o=1.
